// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state encoding and the legal store-strobe set.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_resp_state_e;

    localparam logic [3:0] WSTRB_B0 = 4'b0001;
    localparam logic [3:0] WSTRB_B1 = 4'b0010;
    localparam logic [3:0] WSTRB_B2 = 4'b0100;
    localparam logic [3:0] WSTRB_B3 = 4'b1000;
    localparam logic [3:0] WSTRB_H0 = 4'b0011;
    localparam logic [3:0] WSTRB_H1 = 4'b1100;
    localparam logic [3:0] WSTRB_W  = 4'b1111;

    // Only naturally aligned byte, half and word stores are accepted.
    function automatic logic is_legal_wstrb(input logic [3:0] s);
        logic ok;
        ok = 1'b0;
        unique case (1'b1)
            (s == WSTRB_B0): ok = 1'b1;
            (s == WSTRB_B1): ok = 1'b1;
            (s == WSTRB_B2): ok = 1'b1;
            (s == WSTRB_B3): ok = 1'b1;
            (s == WSTRB_H0): ok = 1'b1;
            (s == WSTRB_H1): ok = 1'b1;
            (s == WSTRB_W):  ok = 1'b1;
            default:         ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side dmem request/response bundle.
// The core drives the request as master; the memory answers as slave.
interface dmem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   dmem_addr;
    logic                    dmem_read;
    logic                    dmem_write;
    logic [DATA_WIDTH-1:0]   dmem_wdata;
    logic [DATA_WIDTH/8-1:0] dmem_wstrb;
    logic [DATA_WIDTH-1:0]   dmem_rdata;
    logic                    dmem_ready;
    logic                    dmem_err;

    modport master (
        output dmem_addr,
        output dmem_read,
        output dmem_write,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_rdata,
        input  dmem_ready,
        input  dmem_err
    );

    modport slave (
        input  dmem_addr,
        input  dmem_read,
        input  dmem_write,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_rdata,
        output dmem_ready,
        output dmem_err
    );

endinterface

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM with per-byte-lane write enables.
// Synchronous write, combinational read; contents are never reset.
module dmem_byte_ram #(
    parameter int DEPTH = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int IW = $clog2(DEPTH)
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [IW-1:0]           addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    localparam int LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: one request at a time, fixed wait states,
// one-cycle ready/err response, byte-strobed writes at end of response.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH       = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input logic             clk,
    input logic             rst_n,
    dmem_responder_if.slave dmem
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] BASE_X = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(DEPTH) << 2;
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    dmem_resp_state_e state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;
    logic                  read_q, read_d;
    logic                  write_q, write_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH:0]   off;
    logic                  req_err;
    logic                  unused_off;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic                  ready;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;

    // One wide subtract: a borrow lands in the top bit, so addresses
    // below the base also compare as >= SPAN.
    assign off = {1'b0, dmem.dmem_addr} - BASE_X;
    assign unused_off = ^off;

    assign req_err = (off >= SPAN)
        | (dmem.dmem_write & ~is_legal_wstrb(dmem.dmem_wstrb))
        | (dmem.dmem_read & dmem.dmem_write);

    dmem_byte_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .be_i    (wstrb_q),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            read_q  <= read_d;
            write_q <= write_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        read_d  = read_q;
        write_d = write_q;
        err_d   = err_q;
        ready   = 1'b0;
        err     = 1'b0;
        rdata   = '0;
        ram_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dmem.dmem_read | dmem.dmem_write) begin
                    idx_d   = off[2 +: IW];
                    wdata_d = dmem.dmem_wdata;
                    wstrb_d = dmem.dmem_wstrb;
                    read_d  = dmem.dmem_read;
                    write_d = dmem.dmem_write;
                    err_d   = req_err;
                    if (WS == 4'd0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WS;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                ready   = 1'b1;
                err     = err_q;
                ram_we  = write_q & ~err_q;
                state_d = IDLE;
                if (read_q & ~err_q) begin
                    rdata = ram_rdata;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dmem.dmem_ready = ready;
    assign dmem.dmem_err   = err;
    assign dmem.dmem_rdata = rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at 0, 1 and 15 wait states.
// Drivers queue expectations; a negedge monitor checks every response.
module tb_dmem_responder;

    typedef struct {
        int          k;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic [31:0] a_d [3];
    logic [31:0] wd_d [3];
    logic [3:0]  st_d [3];
    logic        rd_d [3];
    logic        wr_d [3];
    logic [31:0] rdata_m [3];
    logic        rdy_m [3];
    logic        err_m [3];
    logic        prev_rdy [3] = '{1'b0, 1'b0, 1'b0};
    bit          at_ready [3] = '{1'b0, 1'b0, 1'b0};

    exp_t sbq [$];

    for (genvar g = 0; g < 3; g++) begin : gi
        dmem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
        assign bus.dmem_addr  = a_d[g];
        assign bus.dmem_read  = rd_d[g];
        assign bus.dmem_write = wr_d[g];
        assign bus.dmem_wdata = wd_d[g];
        assign bus.dmem_wstrb = st_d[g];
        assign rdata_m[g] = bus.dmem_rdata;
        assign rdy_m[g]   = bus.dmem_ready;
        assign err_m[g]   = bus.dmem_err;

        dmem_responder #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .DEPTH       (1024),
            .BASE_ADDR   (32'h0000_0000),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 1 : 15))
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .dmem  (bus)
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 15);
    endfunction

    always @(negedge clk) begin
        int   idx;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (rdy_m[k] === 1'b1) begin
                idx = -1;
                foreach (sbq[i]) if (idx < 0 && sbq[i].k == k) idx = i;
                checks++;
                if (idx < 0) begin
                    fails++;
                    $display("FAIL spurious_ready[%0d] cyc=%0d got ready=1 want no response", k, cyc);
                end else begin
                    e = sbq[idx];
                    sbq.delete(idx);
                    checks++;
                    if (rdata_m[k] !== e.rdata) begin
                        fails++;
                        $display("FAIL rdata[%0d] cyc=%0d got %h want %h", k, cyc, rdata_m[k], e.rdata);
                    end
                    checks++;
                    if (err_m[k] !== e.err) begin
                        fails++;
                        $display("FAIL err[%0d] cyc=%0d got %b want %b", k, cyc, err_m[k], e.err);
                    end
                    checks++;
                    if (cyc != e.due) begin
                        fails++;
                        $display("FAIL latency[%0d] ready at cyc %0d want cyc %0d", k, cyc, e.due);
                    end
                end
                checks++;
                if (prev_rdy[k]) begin
                    fails++;
                    $display("FAIL ready_width[%0d] cyc=%0d got 2+ cycles want 1", k, cyc);
                end
            end else begin
                checks++;
                if (rdata_m[k] !== 32'h0) begin
                    fails++;
                    $display("FAIL rdata_idle[%0d] cyc=%0d got %h want 0", k, cyc, rdata_m[k]);
                end
            end
            prev_rdy[k] = rdy_m[k];
        end
    end

    task automatic drive(input int k, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st);
        rd_d[k] = rd;
        wr_d[k] = wr;
        a_d[k]  = a;
        wd_d[k] = wd;
        st_d[k] = st;
    endtask

    task automatic idle(input int k);
        drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        at_ready[k] = 1'b0;
    endtask

    // Issue one request (back-to-back when called on a ready negedge)
    // and hold it until ready; chg swaps the address after capture.
    task automatic req(input int k, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic [31:0] er,
                       input logic ee, input bit chg,
                       input logic [31:0] a_alt);
        exp_t e;
        int   n;
        e.k     = k;
        e.rdata = er;
        e.err   = ee;
        e.due   = (at_ready[k] ? cyc + 1 : cyc) + 1 + ws_of(k);
        sbq.push_back(e);
        drive(k, rd, wr, a, wd, st);
        n = 0;
        do begin
            @(negedge clk);
            if (chg && n == 0) a_d[k] = a_alt;
            n++;
        end while (rdy_m[k] !== 1'b1 && n < 40);
        if (rdy_m[k] !== 1'b1) begin
            checks++;
            fails++;
            $display("FAIL timeout[%0d] no ready within 40 cycles of addr %h", k, a);
        end
        at_ready[k] = 1'b1;
    endtask

    task automatic chk_quiet(input string nm);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rdy_m[k] !== 1'b0 || err_m[k] !== 1'b0 || rdata_m[k] !== 32'h0) begin
                fails++;
                $display("FAIL %s[%0d] got rdy=%b err=%b rdata=%h want 0/0/0",
                         nm, k, rdy_m[k], err_m[k], rdata_m[k]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        chk_quiet("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);

        req(1, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0, 0);
        idle(1);
        req(1, 1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, 0);
        idle(1);
        req(1, 1, 0, 32'h13, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, 0);
        idle(1);

        req(1, 0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, 0, 0);
        idle(1);
        req(1, 0, 1, 32'h22, 32'h00AA0000, 4'b0100, 32'h0, 0, 0, 0);
        idle(1);
        req(1, 1, 0, 32'h20, 32'h0, 4'h0, 32'h11AA3344, 0, 0, 0);
        idle(1);
        req(1, 0, 1, 32'h22, 32'hBEEF0000, 4'b1100, 32'h0, 0, 0, 0);
        idle(1);
        req(1, 1, 0, 32'h20, 32'h0, 4'h0, 32'hBEEF3344, 0, 0, 0);
        idle(1);

        req(1, 1, 0, 32'h1000, 32'h0, 4'h0, 32'h0, 1, 0, 0);
        idle(1);
        req(1, 0, 1, 32'h10, 32'h55555555, 4'b0110, 32'h0, 1, 0, 0);
        idle(1);
        req(1, 0, 1, 32'h10, 32'h66666666, 4'b0000, 32'h0, 1, 0, 0);
        idle(1);
        req(1, 1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, 0);
        idle(1);
        req(1, 1, 1, 32'h10, 32'h77777777, 4'hF, 32'h0, 1, 0, 0);
        idle(1);
        req(1, 1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0, 0);
        idle(1);

        req(1, 1, 0, 32'h20, 32'h0, 4'h0, 32'hBEEF3344, 0, 1, 32'h10);
        req(1, 1, 0, 32'h20, 32'h0, 4'h0, 32'hBEEF3344, 0, 0, 0);
        idle(1);
        req(2, 1, 0, 32'h20, 32'h0, 4'h0, 32'h0, 0, 0, 0);
        idle(2);
        req(2, 0, 1, 32'h20, 32'hCAFEF00D, 4'hF, 32'h0, 0, 1, 32'h1000);
        req(2, 1, 0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 0, 0, 0);
        idle(2);

        for (int k = 0; k < 3; k++) begin
            req(k, 0, 1, 32'h40, 32'hA5000000 | k, 4'hF, 32'h0, 0, 0, 0);
            req(k, 1, 0, 32'h40, 32'h0, 4'h0, 32'hA5000000 | k, 0, 0, 0);
            req(k, 1, 0, 32'h44, 32'h0, 4'h0, 32'h0, 0, 0, 0);
            idle(k);
        end

        req(1, 0, 1, 32'h30, 32'h12345678, 4'hF, 32'h0, 0, 0, 0);
        idle(1);
        drive(1, 1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk_quiet("midreset_outputs");
        repeat (2) @(negedge clk);
        chk_quiet("held_reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        req(1, 1, 0, 32'h30, 32'h0, 4'h0, 32'h12345678, 0, 0, 0);
        idle(1);

        repeat (20) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL sb_drain got %0d pending want 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
